// File: rtl/fir_dec_buf.sv
// fir_dec_buf: keeps 1 of every DECIM valid FIR output samples, rounds and
// scales them from 19 to 16 bits, and buffers them in a first-word
// fall-through FIFO of DEPTH entries with a sticky overflow flag.
// Optional macro FIR_DEC_BUF_SAT_EN: saturate the scaled sample to the
// 16-bit range instead of wrapping.
module fir_dec_buf #(
    parameter int DECIM = 2,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [18:0] din,
    input  logic               din_vld,
    output logic signed [15:0] dout,
    output logic               dout_vld,
    input  logic               dout_rdy,
    output logic        [4:0]  count,
    output logic               full,
    output logic               ovf
);

    localparam int            PW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
    localparam logic [4:0]    CNT_FULL = 5'(DEPTH);

    // Round half toward +inf while dropping 3 LSBs, then fit into 16 bits.
    function automatic logic signed [15:0] scale_round(input logic signed [18:0] x);
        logic signed [19:0] sum;
        logic signed [15:0] res;
        sum = $signed({x[18], x}) + 20'sd4;
`ifdef FIR_DEC_BUF_SAT_EN
        begin
            logic signed [16:0] r;
            r = 17'(sum >>> 3);
            if (r > 17'sd32767) begin
                res = 16'sh7fff;
            end else if (r < -17'sd32768) begin
                res = 16'sh8000;
            end else begin
                res = r[15:0];
            end
        end
`else
        res = 16'(sum >>> 3);
`endif
        return res;
    endfunction

    logic [PW-1:0]      r_phase;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [4:0]         r_count;
    logic               r_ovf;
    logic signed [15:0] r_mem [DEPTH];

    logic               w_keep;
    logic               w_pop;
    logic               w_push;
    logic               w_empty;
    logic signed [15:0] w_sample;

    assign w_empty  = (r_count == 5'd0);
    assign w_keep   = din_vld && (r_phase == '0);
    assign w_pop    = !w_empty && dout_rdy;
    // A full FIFO still accepts a kept sample when the head leaves this cycle.
    assign w_push   = w_keep && ((r_count != CNT_FULL) || w_pop);
    assign w_sample = scale_round(din);

    // Decimation phase: advances only on valid input, wraps at DECIM-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (din_vld) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    // FIFO control: pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_keep && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FIFO storage: data only, contents are meaningless after reset.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= w_sample;
        end
    end

    // All status outputs decode registered state only.
    assign dout_vld = !w_empty;
    assign full     = (r_count == CNT_FULL);
    assign count    = r_count;
    assign ovf      = r_ovf;
    assign dout     = w_empty ? 16'sd0 : r_mem[r_rptr];

endmodule

// File: tb/tb_fir_dec_buf.sv
// Bench for fir_dec_buf: a DECIM=1 and a DECIM=2 instance share stimulus;
// a queue scoreboard tracks both, plus table vectors and corner sequences.
module tb_fir_dec_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [18:0] din;
    logic               din_vld;
    logic               dout_rdy;

    logic signed [15:0] dout1, dout2;
    logic               dv1, dv2;
    logic [4:0]         c1, c2;
    logic               f1, f2, o1, o2;

    fir_dec_buf #(.DECIM(1), .DEPTH(4)) u_d1 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .dout(dout1), .dout_vld(dv1), .dout_rdy(dout_rdy),
        .count(c1), .full(f1), .ovf(o1)
    );

    fir_dec_buf #(.DECIM(2), .DEPTH(4)) u_d2 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .dout(dout2), .dout_vld(dv2), .dout_rdy(dout_rdy),
        .count(c2), .full(f2), .ovf(o2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] model_scale(input logic signed [18:0] d);
        int v;
        int e;
        v = int'(d) + 4;
        if (v >= 0) e = v / 8;
        else        e = -((-v + 7) / 8);
`ifdef FIR_DEC_BUF_SAT_EN
        if (e > 32767)  e = 32767;
        if (e < -32768) e = -32768;
`endif
        return 16'(e);
    endfunction

    // Scoreboard: checked on the falling edge, then advanced for the next rising edge.
    logic signed [15:0] q1[$];
    logic signed [15:0] q2[$];
    bit armed = 1'b0;
    bit ov1 = 1'b0;
    bit ov2 = 1'b0;
    int ph2 = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("sb1_vld",   dv1,   q1.size() != 0);
            chk("sb1_count", c1,    q1.size());
            chk("sb1_full",  f1,    q1.size() == 4);
            chk("sb1_ovf",   o1,    ov1);
            chk("sb1_dout",  dout1, (q1.size() != 0) ? q1[0] : 16'sd0);
            chk("sb2_vld",   dv2,   q2.size() != 0);
            chk("sb2_count", c2,    q2.size());
            chk("sb2_full",  f2,    q2.size() == 4);
            chk("sb2_ovf",   o2,    ov2);
            chk("sb2_dout",  dout2, (q2.size() != 0) ? q2[0] : 16'sd0);
        end
        if (rst) begin
            q1.delete();
            q2.delete();
            ov1 = 1'b0;
            ov2 = 1'b0;
            ph2 = 0;
            armed = 1'b1;
        end else if (armed) begin
            if (dout_rdy && q1.size() != 0) void'(q1.pop_front());
            if (din_vld) begin
                if (q1.size() < 4) q1.push_back(model_scale(din));
                else               ov1 = 1'b1;
            end
            if (dout_rdy && q2.size() != 0) void'(q2.pop_front());
            if (din_vld && ph2 == 0) begin
                if (q2.size() < 4) q2.push_back(model_scale(din));
                else               ov2 = 1'b1;
            end
            if (din_vld) ph2 = (ph2 + 1) % 2;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_vld = 1'b0;
        dout_rdy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic signed [18:0] din;
        int                 exp;
    } vec_t;

    vec_t vt[6];
    int   ramp_exp[4];

    initial begin
        vt[0] = '{19'sd11, 1};
        vt[1] = '{19'sd12, 2};
        vt[2] = '{-19'sd12, -1};
        vt[3] = '{-19'sd13, -2};
`ifdef FIR_DEC_BUF_SAT_EN
        vt[4] = '{19'sd262143, 32767};
`else
        vt[4] = '{19'sd262143, -32768};
`endif
        vt[5] = '{19'sh40000, -32768};
        ramp_exp = '{1, 3, 5, 7};

        rst = 1'b1;
        din = '0;
        din_vld = 1'b0;
        dout_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_dout", dout1, 0);
        chk("rst_vld", dv1, 0);
        chk("rst_count", c1, 0);
        chk("rst_full", f1, 0);
        chk("rst_ovf", o1, 0);
        chk("rst_vld2", dv2, 0);

        // Rounding and saturation vectors on the DECIM=1 instance
        dout_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = vt[i].din;
            din_vld = 1'b1;
            tick();
            chk($sformatf("vec%0d_dout", i), dout1, vt[i].exp);
            chk($sformatf("vec%0d_vld", i), dv1, 1);
        end
        din_vld = 1'b0;
        tick();
        tick();

        // Ramp through the DECIM=2 instance
        do_reset();
        dout_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 19'(8 * (i + 1));
            din_vld = 1'b1;
            tick();
            chk($sformatf("ramp%0d_vld", i), dv2, (i % 2) == 0);
            chk($sformatf("ramp%0d_dout", i), dout2, ((i % 2) == 0) ? ramp_exp[i / 2] : 0);
        end
        din_vld = 1'b0;
        tick();

        // Overflow with a stalled consumer, then drain
        do_reset();
        for (int i = 0; i < 6; i++) begin
            din = 19'(8 * (i + 1));
            din_vld = 1'b1;
            tick();
            if (i == 3) begin
                chk("ovf_cnt4", c1, 4);
                chk("ovf_full4", f1, 1);
                chk("ovf_flag4", o1, 0);
            end
            if (i == 4) begin
                chk("ovf_cnt5", c1, 4);
                chk("ovf_full5", f1, 1);
                chk("ovf_flag5", o1, 1);
            end
        end
        din_vld = 1'b0;
        dout_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), dout1, k + 1);
            tick();
        end
        chk("drain_cnt", c1, 0);
        chk("drain_ovf", o1, 1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) begin
            din = 19'(8 * (i + 1));
            din_vld = 1'b1;
            tick();
        end
        din = 19'sd40;
        din_vld = 1'b1;
        dout_rdy = 1'b1;
        tick();
        din_vld = 1'b0;
        dout_rdy = 1'b0;
        chk("pp_cnt", c1, 4);
        chk("pp_ovf", o1, 0);
        chk("pp_head", dout1, 2);
        chk("pp_full", f1, 1);
        tick();

        // Reset mid-stream with count=3, phase=1, competing push and pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            din = 19'(8 * (i + 1));
            din_vld = 1'b1;
            tick();
        end
        chk("mid_cnt2", c2, 3);
        rst = 1'b1;
        din = 19'sd72;
        din_vld = 1'b1;
        dout_rdy = 1'b1;
        tick();
        rst = 1'b0;
        din = 19'sd80;
        din_vld = 1'b1;
        dout_rdy = 1'b0;
        chk("mid_cnt", c2, 0);
        chk("mid_vld", dv2, 0);
        chk("mid_dout", dout2, 0);
        chk("mid_ovf2", o2, 0);
        chk("mid_ovf1", o1, 0);
        chk("mid_cnt1", c1, 0);
        tick();
        din_vld = 1'b0;
        chk("mid_keep_vld", dv2, 1);
        chk("mid_keep_dout", dout2, 10);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
